// File: rtl/prio_encoder8_3_seq_pkg.sv
// Shared definitions for the sequential 8-to-3 priority encoder.
//   REQ_W / CODE_W : request vector width and binary index width
//   ST_IDLE / ST_PRESENT : FSM state encoding (single state bit)
package prio_encoder8_3_seq_pkg;

  localparam int REQ_W  = 8;
  localparam int CODE_W = 3;

  localparam logic ST_IDLE    = 1'b0;
  localparam logic ST_PRESENT = 1'b1;

endpackage

// File: rtl/prio_encoder8_3_seq_core.sv
// Combinational 8-to-3 priority encoder.
//   LSB_PRIORITY : 0 -> highest set index wins, 1 -> lowest set index wins
//   vec          : input request vector
//   idx          : index of the winning bit (0 when vec is empty)
//   any          : at least one bit of vec is set
module prio_enc8_core
  import prio_encoder8_3_seq_pkg::*;
#(
  parameter bit LSB_PRIORITY = 1'b0
) (
  input  logic [REQ_W-1:0]  vec,
  output logic [CODE_W-1:0] idx,
  output logic              any
);

  // Later loop iterations overwrite earlier ones, so the scan direction
  // decides which end of the vector has priority.
  always_comb begin
    idx = '0;
    any = |vec;
    if (LSB_PRIORITY) begin
      for (int i = REQ_W - 1; i >= 0; i--) begin
        if (vec[i]) idx = CODE_W'(i);
      end
    end else begin
      for (int i = 0; i < REQ_W; i++) begin
        if (vec[i]) idx = CODE_W'(i);
      end
    end
  end

endmodule

// File: rtl/prio_encoder8_3_seq.sv
// Sequential 8-to-3 priority encoder with sticky pending register.
// Requests are captured into pend; one index at a time is presented on a
// valid/ready handshake and the serviced pending bit is cleared.
//   clk   : rising-edge clock
//   rst   : asynchronous active-high reset
//   en    : capture / issue enable
//   req   : multi-hot request lines, sampled every clock
//   ready : consumer accepts the presented code
//   code  : binary index of the presented request
//   valid : code is valid
//   pend  : current pending register (status)
module prio_encoder8_3_seq
  import prio_encoder8_3_seq_pkg::*;
#(
  parameter bit LSB_PRIORITY = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [REQ_W-1:0]  req,
  input  logic              ready,
  output logic [CODE_W-1:0] code,
  output logic              valid,
  output logic [REQ_W-1:0]  pend
);

  logic              state;
  logic              state_nxt;
  logic [CODE_W-1:0] enc_idx;
  logic              enc_any;
  logic              accept;
  logic              load_code;
  logic [REQ_W-1:0]  clr_mask;
  logic [REQ_W-1:0]  pend_nxt;

  // The encoder looks at the registered pend, never at req directly, so a
  // request needs one edge to land in pend and another to be presented.
  prio_enc8_core #(
    .LSB_PRIORITY (LSB_PRIORITY)
  ) u_core (
    .vec (pend),
    .idx (enc_idx),
    .any (enc_any)
  );

  assign accept    = valid & ready;
  assign load_code = (state == ST_IDLE) & en & enc_any;

  // Clear is applied before the OR, so a request re-asserted on the
  // accept edge keeps its bit pending.
  always_comb begin
    clr_mask = '0;
    if (accept) clr_mask = REQ_W'(1) << code;
    pend_nxt = (pend & ~clr_mask) | (en ? req : '0);
  end

  // State, code and pending registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      code  <= '0;
      pend  <= '0;
    end else begin
      state <= state_nxt;
      pend  <= pend_nxt;
      if (load_code) code <= enc_idx;
    end
  end

  // Next-state logic; code is frozen while PRESENT regardless of new requests
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (en && enc_any) state_nxt = ST_PRESENT;
      ST_PRESENT: if (ready)         state_nxt = ST_IDLE;
      default:                       state_nxt = ST_IDLE;
    endcase
  end

  // Output decode from the registered state only
  always_comb begin
    valid = 1'b0;
    if (state == ST_PRESENT) valid = 1'b1;
  end

endmodule

// File: tb/tb_prio_encoder8_3_seq.sv
module tb_prio_encoder8_3_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [7:0] req;
  logic       ready;

  logic [2:0] code0, code1;
  logic       valid0, valid1;
  logic [7:0] pend0, pend1;

  int checks = 0;
  int errors = 0;

  // reference model state, index 0 = MSB priority, 1 = LSB priority
  int m_pend[2];
  bit m_valid[2];
  int m_code[2];
  int q0[$], q1[$];       // expected codes, pushed when a presentation starts
  int acc0[$], acc1[$];   // codes seen on handshakes

  prio_encoder8_3_seq #(.LSB_PRIORITY(1'b0)) dut0 (
    .clk(clk), .rst(rst), .en(en), .req(req), .ready(ready),
    .code(code0), .valid(valid0), .pend(pend0)
  );

  prio_encoder8_3_seq #(.LSB_PRIORITY(1'b1)) dut1 (
    .clk(clk), .rst(rst), .en(en), .req(req), .ready(ready),
    .code(code1), .valid(valid1), .pend(pend1)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // highest set bit = floor(log2(p)); lowest set bit = log2 of isolated LSB
  function automatic int winner(input int p, input bit lsb);
    if (lsb) return $clog2(p & (-p));
    return $clog2(p + 1) - 1;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 2; i++) begin
      m_pend[i] = 0; m_valid[i] = 1'b0; m_code[i] = 0;
    end
    q0.delete(); q1.delete();
  endfunction

  always @(posedge clk) begin
    if (rst) model_reset();
    else begin
      for (int i = 0; i < 2; i++) begin
        int np;
        np = m_pend[i];
        if (m_valid[i] && ready) np = np & ~(1 << m_code[i]);
        if (en) np = np | int'(req);
        if (!m_valid[i]) begin
          if (en && m_pend[i] != 0) begin
            m_code[i]  = winner(m_pend[i], i == 1);
            m_valid[i] = 1'b1;
            if (i == 0) q0.push_back(m_code[i]); else q1.push_back(m_code[i]);
          end
        end else if (ready) begin
          m_valid[i] = 1'b0;
        end
        m_pend[i] = np;
      end
    end
  end

  task automatic mon(input int i);
    int c, p, e;
    bit v;
    c = (i == 0) ? int'(code0)  : int'(code1);
    v = (i == 0) ? valid0 : valid1;
    p = (i == 0) ? int'(pend0)  : int'(pend1);
    check($sformatf("valid%0d", i), int'(v), int'(m_valid[i]));
    check($sformatf("pend%0d", i), p, m_pend[i]);
    if (v && ready) begin
      if (i == 0) begin
        if (q0.size() == 0) check("sb_empty0", 1, 0);
        else begin e = q0.pop_front(); check("sb_code0", c, e); end
        acc0.push_back(c);
      end else begin
        if (q1.size() == 0) check("sb_empty1", 1, 0);
        else begin e = q1.pop_front(); check("sb_code1", c, e); end
        acc1.push_back(c);
      end
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      mon(0);
      mon(1);
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive(input bit e, input logic [7:0] r, input bit rd);
    en = e; req = r; ready = rd;
  endtask

  task automatic check_acc(input string name, input int exp0[$], input int exp1[$]);
    check({name, "_n0"}, acc0.size(), exp0.size());
    check({name, "_n1"}, acc1.size(), exp1.size());
    foreach (exp0[k]) if (k < acc0.size()) check({name, "_seq0"}, acc0[k], exp0[k]);
    foreach (exp1[k]) if (k < acc1.size()) check({name, "_seq1"}, acc1[k], exp1[k]);
    acc0.delete(); acc1.delete();
  endtask

  initial begin
    int snap;
    rst = 1'b1;
    drive(0, 8'h00, 0);
    model_reset();
    tick(2);
    check("rst_valid", int'(valid0), 0);
    check("rst_code", int'(code1), 0);
    check("rst_pend", int'(pend0), 0);
    #2 rst = 1'b0;
    tick(1);

    // single request: valid two edges after the request edge
    drive(1, 8'h04, 1);
    tick(1);
    drive(1, 8'h00, 1);
    check("t1_not_yet", int'(valid0), 0);
    tick(1);
    check("t1_valid", int'(valid0), 1);
    check("t1_code", int'(code0), 2);
    tick(1);
    check("t1_pend_clr", int'(pend0), 0);
    check("t1_valid_low", int'(valid0), 0);
    tick(2);
    check_acc("t1", '{2}, '{2});

    // multi-hot pulse, both priority orders
    drive(1, 8'b1001_0010, 1);
    tick(1);
    drive(1, 8'h00, 1);
    tick(8);
    check("t2_pend_end", int'(pend0), 0);
    check_acc("t2", '{7, 4, 1}, '{1, 4, 7});

    // backpressure: code frozen while a higher-priority bit arrives
    drive(1, 8'h01, 0);
    tick(1);
    drive(1, 8'h00, 0);
    tick(5);
    drive(1, 8'h40, 0);
    tick(1);
    drive(1, 8'h00, 0);
    tick(2);
    check("t4_hold_valid", int'(valid0), 1);
    check("t4_hold_code0", int'(code0), 0);
    check("t4_hold_code1", int'(code1), 0);
    ready = 1'b1;
    tick(6);
    check_acc("t4", '{0, 6}, '{0, 6});

    // set wins over clear on the accept edge
    drive(1, 8'h08, 0);
    tick(1);
    drive(1, 8'h00, 0);
    tick(1);
    check("t5_code", int'(code0), 3);
    drive(1, 8'h08, 1);
    tick(1);
    check("t5_pend_kept", int'(pend0[3]), 1);
    check("t5_bubble", int'(valid0), 0);
    drive(1, 8'h00, 1);
    tick(4);
    check_acc("t5", '{3, 3}, '{3, 3});

    // all eight bits drain in priority order
    drive(1, 8'hFF, 1);
    tick(1);
    drive(1, 8'h00, 1);
    tick(18);
    check_acc("drain", '{7, 6, 5, 4, 3, 2, 1, 0}, '{0, 1, 2, 3, 4, 5, 6, 7});

    // en=0 blocks capture and issue
    snap = int'(pend0);
    drive(0, 8'hFF, 1);
    tick(4);
    check("t6_pend_hold", int'(pend0), snap);
    check("t6_no_valid", int'(valid0), 0);

    // async reset in the middle of a presentation
    drive(1, 8'hFF, 0);
    tick(1);
    drive(1, 8'h00, 0);
    tick(1);
    check("t6_present", int'(valid1), 1);
    #2 rst = 1'b1;
    model_reset();
    #1;
    check("t6_rst_valid", int'(valid0) + int'(valid1), 0);
    check("t6_rst_code", int'(code0) + int'(code1), 0);
    check("t6_rst_pend", int'(pend0) | int'(pend1), 0);
    #3 rst = 1'b0;
    acc0.delete(); acc1.delete();
    tick(1);

    // idle with no requests
    drive(1, 8'h00, 1);
    tick(6);

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      en    = ($urandom_range(0, 9) != 0);
      req   = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
      ready = $urandom_range(0, 1) == 1;
      tick(1);
    end
    drive(1, 8'h00, 1);
    tick(30);
    check("end_sb0", q0.size(), 0);
    check("end_sb1", q1.size(), 0);
    check("end_pend", int'(pend0) | int'(pend1), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/prio_encoder8_3_seq.md
Name: prio_encoder8_3_seq

Overview:
Sequential 8-to-3 priority encoder, the inverse of the team's 3-to-8 one-hot decoder. It captures multi-hot request lines into a sticky pending register. It then presents one 3-bit index at a time on a valid/ready handshake and clears each serviced bit. It sits in front of consumers that take a binary index, such as interrupt or event dispatch, and its output feeds straight into the decoder to recover one-hot grants.

Parameters:
LSB_PRIORITY  0  0: bit 7 has highest priority; 1: bit 0 has highest priority

Ports:
clk      input   1  rising-edge clock
rst      input   1  asynchronous, active-high reset
en       input   1  capture/issue enable
req      input   8  request lines, multi-hot, level-sampled each clk
ready    input   1  consumer accepts current code
code     output  3  binary index of presented request (bit n -> 3'dn)
valid    output  1  code is valid
pend     output  8  current pending register (debug/status)

Behaviour:
- Reset (async, rst=1): pend=8'h00, code=3'b000, valid=0, FSM=IDLE. All outputs are registered, so there is no combinational path from inputs to outputs.
- Capture, every rising edge:
  - pend_next = (pend & ~clr_mask) | (en ? req : 8'h00).
  - clr_mask = one-hot of code when a handshake (valid & ready) occurs that edge, else 0.
  - Set wins over clear: if req[code]=1 and en=1 on the accept edge, that bit stays pending.
- FSM states: IDLE, PRESENT.
  - IDLE: if en=1 and pend!=0, load code from the priority encode of the registered pend, set valid=1, go to PRESENT. Otherwise hold, valid=0, code holds its last value.
  - PRESENT: code and valid stay stable while ready=0; code must not change even if a higher-priority request arrives. On an edge with ready=1: clear pend[code], set valid=0, go to IDLE.
- Priority: with LSB_PRIORITY=0 the highest set index wins; with LSB_PRIORITY=1 the lowest set index wins.
- Latency and throughput:
  - req high before edge k is in pend after edge k; valid=1 after edge k+1 (2 clocks).
  - Accept at edge m clears the bit; the next valid appears no earlier than after edge m+1.
  - One code per 2 clocks maximum; the single IDLE bubble is intended.
- en=0:
  - No new captures and no IDLE->PRESENT transition.
  - A code already in PRESENT completes normally on ready.
  - pend contents are retained.
- Boundary cases:
  - req=8'h00 forever: valid stays 0.
  - All 8 bits set: drains in 8 handshakes in priority order.
  - A request re-asserted while pending is merged and not counted twice.
  - ready=1 while valid=0 is ignored.
- Reset mid-operation: immediate return to reset values; pending requests are lost.

Decomposition:
- Shared package holds:
  - FSM state constants ST_IDLE=1'b0, ST_PRESENT=1'b1.
  - Width constants REQ_W=8 and CODE_W=3.
- One combinational sub-module, prio_enc8_core: inputs vec[7:0] and LSB_PRIORITY, outputs idx[2:0] and any. It is reused by the FSM.

Test Plan:
1. Reset, then req=8'b0000_0100 for 1 clk, ready=1 -> valid after 2 clks with code=3'd2; pend=0 after accept; valid=0 next clk.
2. req=8'b1001_0010 pulse, ready=1 held, LSB_PRIORITY=0 -> codes 7, 4, 1 on successive valids every 2 clks; pend ends at 8'h00.
3. Same stimulus with LSB_PRIORITY=1 -> codes 1, 4, 7.
4. Backpressure: req=8'h01, ready=0 for 5 clks, then req adds bit 6 -> code stays 0 with valid=1 through the stall; after ready, next code=6.
5. Set-wins: in PRESENT with code=3, ready=1 and req[3]=1 on the same edge -> pend[3] remains 1; code 3 is re-presented after the bubble.
6. en=0 with req=8'hFF -> pend unchanged, valid=0. Async rst pulse mid-PRESENT -> valid=0, code=0, pend=0 immediately, without waiting for a clock edge.
